// File: rtl/uart_word_receiver.sv
// uart_word_receiver
//   Serial-load front end. Receives 8N1 UART bytes on Rx_Serial, packs each
//   group of 4 accepted bytes into a 32-bit word (first byte in [31:24]) and
//   presents it with a one-cycle strobe and a 0-based word index. Raises done
//   once MAX_WORDS words have been strobed. Active only while en is high.
//
//   Output protocol: word_valid is a single-cycle strobe with no back-pressure.
//   word_data/word_addr are valid in the strobe cycle and hold until the next
//   strobe. frame_err is a single-cycle pulse and never coincides with
//   word_valid.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   en         in   load enable; low = idle and clear progress
//   Rx_Serial  in   asynchronous serial input, idle high
//   word_valid out  one-cycle strobe for word_data/word_addr
//   word_data  out  assembled 32-bit word
//   word_addr  out  index of the strobed word
//   frame_err  out  one-cycle pulse on a bad stop bit
//   done       out  high once MAX_WORDS words have been strobed
module uart_word_receiver #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_BIT     = 8,
  parameter int MAX_WORDS    = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                Rx_Serial,
  output logic                word_valid,
  output logic [31:0]         word_data,
  output logic [ADDR_BIT-1:0] word_addr,
  output logic                frame_err,
  output logic                done
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int WCW = ADDR_BIT + 1;
  localparam logic [CW-1:0]  HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [WCW-1:0] MAX_C  = WCW'(MAX_WORDS);

  // S_WAIT holds off after a bad stop bit until the line returns high, so a
  // held-low line is not mistaken for a new start bit.
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic [23:0]        shift_q, shift_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic               word_valid_q, word_valid_d;
  logic [31:0]        word_data_q, word_data_d;
  logic [ADDR_BIT-1:0] word_addr_q, word_addr_d;
  logic               frame_err_q, frame_err_d;
  logic               done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    rx_byte_d    = rx_byte_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    word_addr_d  = word_addr_q;
    frame_err_d  = 1'b0;
    done_d       = done_q;

    // Word count advances in the strobe cycle, so done appears one cycle later.
    if (word_valid_q) begin
      word_cnt_d = word_cnt_q + WCW'(1);
      if (word_cnt_q + WCW'(1) == MAX_C) done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d     = '0;
          rx_byte_d = {rx_s_q, rx_byte_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d    = S_IDLE;
            shift_d    = {shift_q[15:0], rx_byte_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3 && !done_q) begin
              word_data_d  = {shift_q, rx_byte_q};
              word_addr_d  = word_cnt_q[ADDR_BIT-1:0];
              word_valid_d = 1'b1;
            end
          end else begin
            state_d     = S_WAIT;
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d      = S_IDLE;
      byte_cnt_d   = '0;
      word_cnt_d   = '0;
      done_d       = 1'b0;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      rx_byte_q    <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_addr_q  <= '0;
      frame_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rx_meta_q    <= Rx_Serial;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_byte_q    <= rx_byte_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_addr_q  <= word_addr_d;
      frame_err_q  <= frame_err_d;
      done_q       <= done_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_addr  = word_addr_q;
  assign frame_err  = frame_err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver
//   Drives 8N1 serial frames into uart_word_receiver and checks its outputs
//   every cycle against a byte/word-level model kept in the bench. The model
//   predicts, per frame sent, whether a word strobe (data, index) or a frame
//   error is due; the compare process consumes those predictions as the DUT
//   produces them and checks hold/exclusivity/done rules in between.
module tb_uart_word_receiver;

  localparam int CPB = 16;
  localparam int AB  = 4;
  localparam int MW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  logic          word_valid;
  logic [31:0]   word_data;
  logic [AB-1:0] word_addr;
  logic          frame_err;
  logic          done;

  uart_word_receiver #(.CLKS_PER_BIT(CPB), .ADDR_BIT(AB), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .en(en), .Rx_Serial(rx),
    .word_valid(word_valid), .word_data(word_data), .word_addr(word_addr),
    .frame_err(frame_err), .done(done)
  );

  // scoreboard and model state
  logic [AB+31:0] exp_q[$];     // {addr, data} of each strobe still due
  int             byte_cnt_m = 0;
  int             word_cnt_m = 0;
  logic [31:0]    shift_m = '0;
  int             ferr_pend = 0;
  logic [31:0]    exp_last_data = '0;
  logic [AB-1:0]  exp_last_addr = '0;
  logic           exp_done = 1'b0;
  logic           wv_prev = 1'b0;
  int             vectors = 0;
  int             miscompares = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // driver tasks
  task automatic drive_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      shift_m = {shift_m[23:0], b};
      byte_cnt_m++;
      if (byte_cnt_m == 4) begin
        byte_cnt_m = 0;
        if (word_cnt_m < MW) begin
          exp_q.push_back({AB'(word_cnt_m), shift_m});
          word_cnt_m++;
        end
      end
    end else begin
      ferr_pend++;
      byte_cnt_m = 0;
    end
    drive_byte(b, stop_ok, $urandom_range(6, 14));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic drop_en();
    @(negedge clk);
    en = 1'b0;
    byte_cnt_m = 0;
    word_cnt_m = 0;
    exp_done = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    byte_cnt_m = 0;
    word_cnt_m = 0;
    exp_done = 1'b0;
    exp_last_data = '0;
    exp_last_addr = '0;
    ferr_pend = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_valid", 36'(word_valid), 36'd0);
    check("rst_data", 36'(word_data), 36'd0);
    check("rst_addr", 36'(word_addr), 36'd0);
    check("rst_ferr", 36'(frame_err), 36'd0);
    check("rst_done", 36'(done), 36'd0);
    reset = 1'b1;
  endtask

  task automatic settle(input string name);
    repeat (30) @(negedge clk);
    check({name, "_pending_words"}, 36'(exp_q.size()), 36'd0);
    check({name, "_pending_ferr"}, 36'(ferr_pend), 36'd0);
  endtask

  // compare process: every cycle, just after the active edge
  initial begin
    logic [AB+31:0] e;
    forever begin
      @(posedge clk);
      #1;
      check("done", 36'(done), 36'(exp_done));
      if (word_valid) begin
        check("double_strobe", 36'(wv_prev), 36'd0);
        check("ferr_with_strobe", 36'(frame_err), 36'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 36'(word_data), 36'hx_dead_dead);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 36'(word_data), 36'(e[31:0]));
          check("word_addr", 36'(word_addr), 36'(e[AB+31:32]));
          exp_last_data = e[31:0];
          exp_last_addr = e[AB+31:32];
          if (e[AB+31:32] == AB'(MW - 1)) exp_done = 1'b1;
        end
      end else begin
        check("hold_data", 36'(word_data), 36'(exp_last_data));
        check("hold_addr", 36'(word_addr), 36'(exp_last_addr));
      end
      if (frame_err) begin
        if (ferr_pend == 0) check("unexpected_ferr", 36'(frame_err), 36'd0);
        else ferr_pend--;
      end
      wv_prev = word_valid;
    end
  end

  // test sequence
  initial begin
    repeat (3) @(negedge clk);
    check("init_valid", 36'(word_valid), 36'd0);
    check("init_data", 36'(word_data), 36'd0);
    check("init_done", 36'(done), 36'd0);
    reset = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single word
    send_word(32'h12345678);
    settle("t1");
    check("t1_data_lit", 36'(word_data), 36'h0_1234_5678);
    check("t1_addr_lit", 36'(word_addr), 36'd0);
    check("t1_done_lit", 36'(done), 36'd0);

    // 2: 4-cycle low glitch is rejected, next frames are received normally
    drop_en();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_word(32'hA55A0FF0);
    settle("t2");
    check("t2_data_lit", 36'(word_data), 36'h0_A55A_0FF0);

    // 3: bad stop bit, then a clean word
    drop_en();
    send_byte(8'hAA, 1'b0);
    send_word(32'hDEADBEEF);
    settle("t3");
    check("t3_data_lit", 36'(word_data), 36'h0_DEAD_BEEF);
    check("t3_addr_lit", 36'(word_addr), 36'd0);

    // 4: word limit
    drop_en();
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    settle("t4");
    check("t4_done_lit", 36'(done), 36'd1);
    check("t4_data_lit", 36'(word_data), 36'h0_0000_0002);
    check("t4_addr_lit", 36'(word_addr), 36'd1);

    // 5: partial word dropped by en pulse
    drop_en();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    drop_en();
    send_word(32'h11223344);
    settle("t5");
    check("t5_data_lit", 36'(word_data), 36'h0_1122_3344);
    check("t5_addr_lit", 36'(word_addr), 36'd0);
    check("t5_done_lit", 36'(done), 36'd0);

    // 6: reset in the middle of a data phase
    send_byte(8'h01, 1'b1);
    fork
      drive_byte(8'hFF, 1'b1, 10);
      begin
        repeat (40) @(negedge clk);
        do_reset();
      end
    join
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hF0, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_no_early", 36'(word_data), 36'd0);
    send_byte(8'h0D, 1'b1);
    settle("t6");
    check("t6_data_lit", 36'(word_data), 36'h0_CAFE_F00D);
    check("t6_addr_lit", 36'(word_addr), 36'd0);

    // random traffic: bytes, occasional bad stop bits and enable drops
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) drop_en();
      else send_byte(8'($urandom_range(0, 255)), r != 1);
    end
    settle("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // absolute time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

endmodule
